// File: rtl/riscv_opcodes_pkg.sv
// Instruction encodings shared by the RISC-V front-end blocks.
package riscv_opcodes_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/riscv_state_pkg.sv
// Shared FSM state encodings for the RISC-V front-end blocks.
package riscv_state_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    FAULT = 2'd2
  } imem_state_e;

endpackage

// File: rtl/riscv_imem_fifo.sv
// Small synchronous FIFO with a clear input; the head entry is presented
// combinationally on o_dout.
module riscv_imem_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_clear,
  input  logic [WIDTH-1:0]       i_din,
  output logic [WIDTH-1:0]       o_dout,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_clear) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;

endmodule

// File: rtl/riscv_imem_ctrl.sv
// Instruction-memory access controller: issues pipelined fetch requests,
// buffers returned parcels with PC and fault flags, and drops flushed responses.
module riscv_imem_ctrl
  import riscv_state_pkg::*;
  import riscv_opcodes_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int PARCEL_SIZE = 32,
  parameter int DEPTH       = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [XLEN-1:0]           if_nxt_pc,
  input  logic                      if_stall,
  input  logic                      if_flush,
  output logic                      if_stall_nxt_pc,
  output logic [PARCEL_SIZE-1:0]    if_parcel,
  output logic [XLEN-1:0]           if_parcel_pc,
  output logic [PARCEL_SIZE/16-1:0] if_parcel_valid,
  output logic                      if_parcel_misaligned,
  output logic                      if_parcel_page_fault,
  output logic                      imem_req,
  output logic [XLEN-1:0]           imem_adr,
  input  logic                      imem_ack,
  input  logic                      imem_rvalid,
  input  logic [PARCEL_SIZE-1:0]    imem_q,
  input  logic                      imem_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = PARCEL_SIZE + XLEN + 2;
  localparam logic [PARCEL_SIZE-1:0] NOP_PARCEL = PARCEL_SIZE'(INSTR_NOP);

  imem_state_e r_state;
  imem_state_e w_state_nxt;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] w_discard_nxt;
  logic          r_live;

  logic [CW-1:0]    w_aq_count;
  logic [CW-1:0]    w_pb_count;
  logic             w_aq_empty;
  logic             w_aq_full;
  logic             w_pb_empty;
  logic             w_pb_full;
  logic [XLEN-1:0]  w_aq_head;
  logic [BW-1:0]    w_pb_din;
  logic [BW-1:0]    w_pb_head;

  logic             w_aligned;
  logic [CW:0]      w_inflight;
  logic             w_credit;
  logic             w_req;
  logic             w_accept;
  logic             w_resp;
  logic             w_inject;
  logic             w_pb_push;
  logic             w_pb_pop;
  logic [CW-1:0]    w_flush_total;
  logic [CW-1:0]    w_flush_load;

  // Holds off requests until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_live <= 1'b0;
    else       r_live <= 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= RUN;
      r_discard <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_discard <= w_discard_nxt;
    end
  end

  assign w_aligned     = (if_nxt_pc[1:0] == 2'b00);
  assign w_inflight    = {1'b0, w_aq_count} + {1'b0, w_pb_count};
  assign w_credit      = r_live & ~w_pb_full & ~w_aq_full & (w_inflight < (CW+1)'(DEPTH));
  assign w_flush_total = w_aq_count + r_discard;
  assign w_flush_load  = (imem_rvalid && (w_flush_total != '0)) ? w_flush_total - CW'(1)
                                                                : w_flush_total;

  // Only one of address-queue count and discard is non-zero at a time, so their
  // sum is the number of responses still owed by the memory on a flush.
  always_comb begin
    w_state_nxt   = r_state;
    w_discard_nxt = r_discard;
    w_req         = 1'b0;
    w_resp        = 1'b0;
    w_inject      = 1'b0;
    case (r_state)
      RUN: begin
        w_req  = w_credit & ~if_flush & w_aligned;
        w_resp = imem_rvalid & ~if_flush;
        if (!if_flush && !w_aligned && w_aq_empty && w_credit) begin
          w_inject    = 1'b1;
          w_state_nxt = FAULT;
        end
      end
      FAULT: begin
        w_resp = imem_rvalid & ~if_flush;
      end
      DRAIN: begin
        if (imem_rvalid && (r_discard != '0)) w_discard_nxt = r_discard - CW'(1);
        if (w_discard_nxt == '0) w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
    if (if_flush) begin
      w_discard_nxt = w_flush_load;
      w_state_nxt   = (w_flush_load != '0) ? DRAIN : RUN;
    end
  end

  assign w_accept  = w_req & imem_ack;
  assign w_pb_push = w_resp | w_inject;
  assign w_pb_pop  = ~w_pb_empty & ~if_stall;
  assign w_pb_din  = w_inject ? {NOP_PARCEL, if_nxt_pc, 1'b1, 1'b0}
                              : {imem_q, w_aq_head, 1'b0, imem_err};

  riscv_imem_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_addr_q (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_accept),
    .i_pop   (w_resp),
    .i_clear (if_flush),
    .i_din   (if_nxt_pc),
    .o_dout  (w_aq_head),
    .o_empty (w_aq_empty),
    .o_full  (w_aq_full),
    .o_count (w_aq_count)
  );

  riscv_imem_fifo #(
    .WIDTH (BW),
    .DEPTH (DEPTH)
  ) u_pbuf (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_pb_push),
    .i_pop   (w_pb_pop),
    .i_clear (if_flush),
    .i_din   (w_pb_din),
    .o_dout  (w_pb_head),
    .o_empty (w_pb_empty),
    .o_full  (w_pb_full),
    .o_count (w_pb_count)
  );

  assign imem_req             = w_req;
  assign imem_adr             = if_nxt_pc;
  assign if_stall_nxt_pc      = ~w_accept;
  assign if_parcel            = w_pb_empty ? NOP_PARCEL : w_pb_head[BW-1 -: PARCEL_SIZE];
  assign if_parcel_pc         = w_pb_empty ? '0 : w_pb_head[XLEN+1:2];
  assign if_parcel_misaligned = ~w_pb_empty & w_pb_head[1];
  assign if_parcel_page_fault = ~w_pb_empty & w_pb_head[0];
  assign if_parcel_valid      = {(PARCEL_SIZE/16){~w_pb_empty}};

endmodule
